// File: rtl/seq_pkg.sv
// Shared types for the nibble sequence player.
//   nibble_t : one 4-bit pattern entry
//   state_t  : playback controller state
package seq_pkg;

    localparam int unsigned NIB_W = 4;

    typedef logic [NIB_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mem.sv
// Pattern memory: DEPTH x 4 register file.
//   clock   : write clock
//   we      : write strobe
//   waddr   : write address
//   wdata   : write nibble
//   raddr   : read address (asynchronous read)
//   rdata   : read nibble
// Contents are deliberately not reset.
module seq_mem
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [NIB_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [NIB_W-1:0] rdata
);

    nibble_t mem_q [DEPTH];

    // Single synchronous write port
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/seq_player.sv
// Playback controller streaming programmable nibble sequences.
//   clock, reset         : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data: pattern write port (IDLE only)
//   len, rep             : length and pass count, sampled on accepted start
//   start, abort         : start request / stop playback
//   busy                 : high in PLAY and DONE
//   dout/dout_valid/dout_ready : valid/ready nibble stream
//   done                 : one-cycle pulse after the final beat
//   wr_err               : one-cycle pulse after a write dropped while busy
module seq_player
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned RPT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [3:0]       wr_data,
    input  logic [AW:0]      len,
    input  logic [RPT_W-1:0] rep,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic [3:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             done,
    output logic             wr_err
);

    localparam int unsigned LW = AW + 1;

    state_t           state_q, state_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic [LW-1:0]    len_q, len_d;
    logic [RPT_W-1:0] pass_q, pass_d;
    logic [RPT_W-1:0] rep_q, rep_d;
    logic             wr_err_q, wr_err_d;

    logic             mem_we;
    nibble_t          rd_data;
    logic             beat;
    logic             last_idx;

    // Writes only land while idle; a busy write is dropped and flagged
    assign mem_we   = wr_en && (state_q == IDLE);
    assign wr_err_d = wr_en && (state_q != IDLE);

    // idx never exceeds len_q-1 <= DEPTH-1, so the low AW bits address the memory
    seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (idx_q[AW-1:0]),
        .rdata (rd_data)
    );

    assign beat     = (state_q == PLAY) && dout_ready;
    assign last_idx = (idx_q == (len_q - LW'(1)));

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pass_d  = pass_q;
        rep_d   = rep_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    len_d  = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
                    rep_d  = rep;
                    idx_d  = '0;
                    pass_d = RPT_W'(1);
                    state_d = (len == '0) ? DONE : PLAY;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (beat) begin
                    if (last_idx) begin
                        if ((rep_q != '0) && (pass_q == rep_q)) begin
                            state_d = DONE;
                        end else begin
                            idx_d = '0;
                            // rep_q==0 loops forever, pass stays put
                            if (rep_q != '0) begin
                                pass_d = pass_q + RPT_W'(1);
                            end
                        end
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            pass_q   <= '0;
            rep_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            pass_q   <= pass_d;
            rep_q    <= rep_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Outputs decoded straight from registered state
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign dout_valid = (state_q == PLAY);
    assign dout       = (state_q == PLAY) ? rd_data : 4'h0;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_seq_player.sv
module tb_seq_player;

    localparam int unsigned DEPTH = 16;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] len;
    logic [3:0] rep;
    logic       start;
    logic       abort;
    logic       busy;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       done;
    logic       wr_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] model_mem [DEPTH];
    logic [3:0] exp_q [$];

    seq_player #(.DEPTH(16), .AW(4), .RPT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .len        (len),
        .rep        (rep),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .done       (done),
        .wr_err     (wr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        model_mem[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_expected(input int l, input int passes);
        int n;
        n = (l > DEPTH) ? DEPTH : l;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < n; i++)
                exp_q.push_back(model_mem[i]);
    endtask

    task automatic start_seq(input logic [4:0] l, input logic [3:0] r);
        len = l; rep = r; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++;
        if ({busy, dout_valid, done, wr_err, dout} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b valid=%b done=%b wr_err=%b dout=%h, required all 0",
                     busy, dout_valid, done, wr_err, dout);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", busy, dout_valid);
        end
    endtask

    // Exact cycle timing with ready held high
    task automatic test_basic();
        logic [3:0] e;
        write_mem(4'd0, 4'd1); write_mem(4'd1, 4'd2); write_mem(4'd2, 4'd3);
        dout_ready = 1'b1;
        push_expected(3, 1);
        start_seq(5'd3, 4'd1);
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (dout_valid !== 1'b1 || dout !== e || done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_beat%0d: valid=%b dout=%h done=%b, required 1 %h 0",
                         k, dout_valid, dout, done, e);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b busy=%b valid=%b, required 1 1 0", done, busy, dout_valid);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    // Ready toggles 1,0,1,0; dout must hold while stalled
    task automatic test_backpressure();
        logic [3:0] e, held;
        logic       held_v, stop;
        int         beats, dones;
        beats = 0; dones = 0; held_v = 1'b0; held = '0; stop = 1'b0;
        push_expected(3, 1);
        start_seq(5'd3, 4'd1);
        for (int c = 0; c < 40 && !stop; c++) begin
            dout_ready = (c % 2 == 0);
            if (held_v) begin
                n_checks++;
                if (dout_valid !== 1'b1 || dout !== held) begin
                    n_fail++;
                    $display("FAIL bp_hold: valid=%b dout=%h, required 1 %h", dout_valid, dout, held);
                end
            end
            if (done) begin
                dones++; stop = 1'b1;
            end else if (dout_valid && dout_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL bp_beat: dout=%h, required %h", dout, e);
                end
                beats++;
            end
            held_v = dout_valid && !dout_ready;
            held   = dout;
            if (!stop) tick();
        end
        n_checks++;
        if (beats != 3 || dones != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: beats=%0d dones=%0d left=%0d, required 3 1 0", beats, dones, exp_q.size());
        end
        exp_q.delete();
        tick();
    endtask

    // len=2, rep=3: six beats then one done
    task automatic test_repeat();
        logic [3:0] e;
        logic       stop;
        int         beats, dones;
        beats = 0; dones = 0; stop = 1'b0;
        dout_ready = 1'b1;
        push_expected(2, 3);
        start_seq(5'd2, 4'd3);
        for (int c = 0; c < 40 && !stop; c++) begin
            if (done) dones++;
            if (!busy) stop = 1'b1;
            if (dout_valid && dout_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL rep_beat%0d: dout=%h, required %h", beats, dout, e);
                end
                beats++;
            end
            if (!stop) tick();
        end
        n_checks++;
        if (beats != 6 || dones != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rep_count: beats=%0d dones=%0d busy=%b, required 6 1 0", beats, dones, busy);
        end
        exp_q.delete();
    endtask

    // rep=0 loops until abort; no done pulse
    task automatic test_loop_abort();
        logic [3:0] e;
        int         beats, dones;
        beats = 0; dones = 0;
        dout_ready = 1'b1;
        push_expected(2, 4);
        start_seq(5'd2, 4'd0);
        for (int c = 0; c < 40 && beats < 7; c++) begin
            if (done) dones++;
            if (dout_valid && dout_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL loop_beat%0d: dout=%h, required %h", beats, dout, e);
                end
                beats++;
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0 || dones != 0 || beats != 7) begin
            n_fail++;
            $display("FAIL loop_abort: busy=%b valid=%b done=%b dones=%0d beats=%0d, required 0 0 0 0 7",
                     busy, dout_valid, done, dones, beats);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_after: done=%b busy=%b, required 0 0", done, busy);
        end
        exp_q.delete();
    endtask

    // len=0 finishes at once; len>DEPTH clamps to DEPTH beats per pass
    task automatic test_len_bounds();
        logic [3:0] e;
        logic       stop;
        int         beats, dones;
        start_seq(5'd0, 4'd1);
        n_checks++;
        if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_done: done=%b valid=%b busy=%b, required 1 0 1", done, dout_valid, busy);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_idle: busy=%b valid=%b, required 0 0", busy, dout_valid);
        end
        for (int i = 0; i < DEPTH; i++) write_mem(4'(i), 4'(15 - i));
        beats = 0; dones = 0; stop = 1'b0;
        dout_ready = 1'b1;
        push_expected(DEPTH + 5, 2);
        start_seq(5'(DEPTH + 5), 4'd2);
        for (int c = 0; c < 100 && !stop; c++) begin
            if (done) begin dones++; stop = 1'b1; end
            else if (dout_valid && dout_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL clamp_beat%0d: dout=%h, required %h", beats, dout, e);
                end
                beats++;
            end
            tick();
        end
        n_checks++;
        if (beats != 2 * DEPTH || dones != 1) begin
            n_fail++;
            $display("FAIL clamp_count: beats=%0d dones=%0d, required %0d 1", beats, dones, 2 * DEPTH);
        end
        exp_q.delete();
    endtask

    // Write and start while busy, then reset mid-PLAY
    task automatic test_busy_ops();
        logic [3:0] e;
        logic       stop;
        int         beats, dones;
        dout_ready = 1'b0;
        push_expected(3, 1);
        start_seq(5'd3, 4'd1);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'd9;
        start = 1'b1; len = 5'd1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        n_checks++;
        if (wr_err !== 1'b1 || dout_valid !== 1'b1 || dout !== model_mem[0]) begin
            n_fail++;
            $display("FAIL busy_wr_err: wr_err=%b valid=%b dout=%h, required 1 1 %h",
                     wr_err, dout_valid, dout, model_mem[0]);
        end
        tick();
        n_checks++;
        if (wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_wr_err_pulse: wr_err=%b, required 0", wr_err);
        end
        beats = 0; dones = 0; stop = 1'b0;
        dout_ready = 1'b1;
        for (int c = 0; c < 20 && !stop; c++) begin
            if (done) begin dones++; stop = 1'b1; end
            else if (dout_valid && dout_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL busy_beat%0d: dout=%h, required %h", beats, dout, e);
                end
                beats++;
            end
            tick();
        end
        n_checks++;
        if (beats != 3 || dones != 1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: beats=%0d dones=%0d, required 3 1", beats, dones);
        end
        exp_q.delete();

        start_seq(5'd16, 4'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, dout_valid, done, wr_err, dout} !== 8'h00) begin
            n_fail++;
            $display("FAIL midplay_reset: busy=%b valid=%b done=%b wr_err=%b dout=%h, required all 0",
                     busy, dout_valid, done, wr_err, dout);
        end
        push_expected(2, 1);
        start_seq(5'd2, 4'd1);
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (dout_valid !== 1'b1 || dout !== e) begin
                n_fail++;
                $display("FAIL retain_beat%0d: valid=%b dout=%h, required 1 %h", k, dout_valid, dout, e);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL retain_done: done=%b, required 1", done);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        len = '0; rep = '0; start = 1'b0; abort = 1'b0; dout_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_repeat();
        test_loop_abort();
        test_len_bounds();
        test_busy_ops();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
